// File: rtl/fifo_traffic_checker.sv
// fifo_traffic_checker: self-checking traffic master for one FIFO instance.
// Drives writes and reads from a seeded LFSR, rebuilds the read stream and
// checks read data and flags against an internal occupancy model.
// Ports: clk_i/rst_i (async active-high); start_i, mode_i run control;
// wr_en_o/wr_data_o and rd_en_o/rd_data_i to the FIFO; full_i, empty_i,
// almost_full_i, almost_empty_i FIFO flags with af_th_i/ae_th_i thresholds;
// busy_o, done_o, pass_o, timeout_o, err_cnt_o, flag_err_o, first_err_idx_o.
// Define FIFO_TRAFFIC_AFLAG_CHK_EN to also check the almost-full/empty flags.
module fifo_traffic_checker #(
  parameter int          DATA_WIDTH = 36,
  parameter int          DEPTH      = 512,
  parameter int          CNT_WIDTH  = $clog2(DEPTH) + 1,
  parameter int          RD_LATENCY = 1,
  parameter int          NUM_WORDS  = 1024,
  parameter logic [31:0] SEED       = 32'h1,
  parameter int          TIMEOUT_W  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [CNT_WIDTH-1:0]  af_th_i,
  input  logic [CNT_WIDTH-1:0]  ae_th_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  full_i,
  input  logic                  empty_i,
  input  logic                  almost_full_i,
  input  logic                  almost_empty_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_cnt_o,
  output logic                  flag_err_o,
  output logic [15:0]           first_err_idx_o
);
  typedef enum logic [2:0] {IDLE, FILL, DRAIN, STREAM, FLUSH, DONE} state_t;
  localparam int REP = (DATA_WIDTH + 31) / 32;
  localparam logic [15:0] NUM = 16'(NUM_WORDS);
  // Galois form of x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? (s >> 1) ^ 32'h8020_0003 : s >> 1;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] word(input logic [31:0] s);
    logic [32*REP-1:0] r;
    r = {REP{s}};
    return r[DATA_WIDTH-1:0];
  endfunction
  state_t                state_q, state_d;
  logic                  mode2_q, mode2_d;
  logic [31:0]           wr_lfsr_q, wr_lfsr_d, exp_lfsr_q, exp_lfsr_d, fr_lfsr_q, fr_lfsr_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, cmp_cnt_q, cmp_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d, first_idx_q, first_idx_d;
  logic                  flag_err_q, flag_err_d, timeout_q, timeout_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [2:0]            fl_cnt_q, fl_cnt_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic wr_room, active, start_ok, wr_acc, rd_acc, tap, mism, flag_bad, wd_ovf;
  assign wr_room  = wr_cnt_q < NUM;
  assign active   = state_q inside {FILL, DRAIN, STREAM};
  assign busy_o   = active | (state_q == FLUSH);
  assign start_ok = start_i & (state_q inside {IDLE, DONE});
  // enables already include the flag qualification, so they are the accepts
  assign wr_acc = ~full_i & wr_room &
                  ((state_q == FILL) | ((state_q == STREAM) & (~mode2_q | fr_lfsr_q[3])));
  assign rd_acc = ~empty_i & ((state_q == DRAIN) |
                  ((state_q == STREAM) & (rd_cnt_q < NUM) & (~mode2_q | fr_lfsr_q[7])));
  assign tap    = vld_q[RD_LATENCY-1];
  assign mism   = tap & (rd_data_i != word(exp_lfsr_q));
  assign wd_ovf = active & (&wd_q) & ~(wr_acc | rd_acc);
`ifdef FIFO_TRAFFIC_AFLAG_CHK_EN
  assign flag_bad = busy_o & ((full_i != (occ_q == CNT_WIDTH'(DEPTH))) | (empty_i != (occ_q == '0)) |
                    (almost_full_i != (occ_q >= af_th_i)) | (almost_empty_i != (occ_q <= ae_th_i)));
`else
  logic unused_aflag;
  assign unused_aflag = ^{almost_full_i, almost_empty_i, af_th_i, ae_th_i};
  assign flag_bad = busy_o & ((full_i != (occ_q == CNT_WIDTH'(DEPTH))) | (empty_i != (occ_q == '0)));
`endif
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = '0;
    case (state_q)
      IDLE, DONE: state_d = start_i ? (mode_i == 2'd0 ? FILL : STREAM) : state_q;
      FILL:       state_d = (full_i | ~wr_room) ? DRAIN : FILL;
      DRAIN:      state_d = empty_i ? (wr_room ? FILL : FLUSH) : DRAIN;
      STREAM:     state_d = (rd_cnt_q == NUM) ? FLUSH : STREAM;
      FLUSH: begin
        fl_cnt_d = fl_cnt_q + 3'd1;
        state_d  = (fl_cnt_q == 3'(RD_LATENCY - 1)) ? DONE : FLUSH;
      end
      default:    state_d = IDLE;
    endcase
    if (wd_ovf) state_d = FLUSH;
  end
  assign mode2_d     = start_ok ? (mode_i == 2'd2) : mode2_q;
  assign wr_lfsr_d   = start_ok ? SEED : wr_acc ? lfsr_next(wr_lfsr_q) : wr_lfsr_q;
  assign exp_lfsr_d  = start_ok ? SEED : tap ? lfsr_next(exp_lfsr_q) : exp_lfsr_q;
  assign fr_lfsr_d   = start_ok ? SEED : lfsr_next(fr_lfsr_q);
  assign occ_d       = start_ok ? '0 : occ_q + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(rd_acc);
  assign wr_cnt_d    = start_ok ? '0 : wr_cnt_q + 16'(wr_acc);
  assign rd_cnt_d    = start_ok ? '0 : rd_cnt_q + 16'(rd_acc);
  assign cmp_cnt_d   = start_ok ? '0 : cmp_cnt_q + 16'(tap);
  assign err_cnt_d   = start_ok ? '0 : err_cnt_q + 16'(mism & ~(&err_cnt_q));
  assign first_idx_d = start_ok ? '0 : (mism & (err_cnt_q == '0)) ? cmp_cnt_q : first_idx_q;
  assign flag_err_d  = ~start_ok & (flag_err_q | flag_bad);
  assign timeout_d   = ~start_ok & (timeout_q | wd_ovf);
  assign wd_d        = (~active | wr_acc | rd_acc) ? '0 : wd_q + 1'b1;
  assign vld_d       = RD_LATENCY'({vld_q, rd_acc});
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode2_q     <= 1'b0;
      wr_lfsr_q   <= SEED;
      exp_lfsr_q  <= SEED;
      fr_lfsr_q   <= SEED;
      occ_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      cmp_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      flag_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
      vld_q       <= '0;
      fl_cnt_q    <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mode2_q     <= mode2_d;
      wr_lfsr_q   <= wr_lfsr_d;
      exp_lfsr_q  <= exp_lfsr_d;
      fr_lfsr_q   <= fr_lfsr_d;
      occ_q       <= occ_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cmp_cnt_q   <= cmp_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      flag_err_q  <= flag_err_d;
      timeout_q   <= timeout_d;
      vld_q       <= vld_d;
      fl_cnt_q    <= fl_cnt_d;
      wd_q        <= wd_d;
    end
  end
  assign wr_en_o         = wr_acc;
  assign rd_en_o         = rd_acc;
  assign wr_data_o       = wr_acc ? word(wr_lfsr_q) : '0;
  assign done_o          = state_q == DONE;
  assign pass_o          = done_o & (err_cnt_q == '0) & ~flag_err_q & ~timeout_q & (rd_cnt_q == NUM);
  assign timeout_o       = timeout_q;
  assign err_cnt_o       = err_cnt_q;
  assign flag_err_o      = flag_err_q;
  assign first_err_idx_o = first_idx_q;
endmodule

// File: tb/tb_fifo_traffic_checker.sv
// tb_fifo_traffic_checker: scoreboard bench driving the checker against a FIFO model with faults.
module tb_fifo_traffic_checker;
  localparam int DW = 36, DEPTH = 512, CW = 10, LAT = 2, NUM = 1024;
  localparam logic [31:0] SEED = 32'h1;
  localparam logic [31:0] POLY = 32'h8020_0003;
  typedef struct {
    string     name;
    bit        pass;
    bit [15:0] err;
    bit [15:0] idx;
    bit        flag;
    bit        to;
  } exp_t;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic [CW-1:0] af_th_i = CW'(500), ae_th_i = CW'(10);
  logic wr_en_o, rd_en_o, busy_o, done_o, pass_o, timeout_o, flag_err_o;
  logic [DW-1:0] wr_data_o, rd_data_i = '0, stage = '0, w_tmp;
  logic full_i, empty_i, almost_full_i, almost_empty_i;
  logic [15:0] err_cnt_o, first_err_idx_o;
  int checks = 0, failures = 0, fcnt = 0, rd_idx = 0, wr_seen = 0;
  bit f_corrupt = 0, f_full_low = 0, f_empty_pin = 0, done_prev = 0;
  logic [DW-1:0] mem[$];
  logic [31:0] wl = SEED;
  exp_t exp_q[$];
  exp_t e;

  fifo_traffic_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .RD_LATENCY(LAT),
    .NUM_WORDS(NUM), .SEED(SEED), .TIMEOUT_W(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .af_th_i(af_th_i),
    .ae_th_i(ae_th_i), .wr_en_o(wr_en_o), .wr_data_o(wr_data_o), .rd_en_o(rd_en_o),
    .rd_data_i(rd_data_i), .full_i(full_i), .empty_i(empty_i), .almost_full_i(almost_full_i),
    .almost_empty_i(almost_empty_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .flag_err_o(flag_err_o),
    .first_err_idx_o(first_err_idx_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ ({32{s[0]}} & POLY);
  endfunction
  function automatic logic [DW-1:0] word(input logic [31:0] s);
    logic [63:0] r;
    r = {s, s};
    return r[DW-1:0];
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  assign full_i         = (fcnt == DEPTH) && !f_full_low;
  assign empty_i        = (fcnt == 0) || f_empty_pin;
  assign almost_full_i  = fcnt >= int'(af_th_i);
  assign almost_empty_i = fcnt <= int'(ae_th_i);

  // FIFO model, two-cycle registered read path
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i || (start_i && !busy_o)) begin
      mem.delete();
      fcnt <= 0;
      rd_idx <= 0;
      stage <= '0;
      rd_data_i <= '0;
    end else begin
      if (rd_en_o && !empty_i && mem.size() > 0) begin
        w_tmp = mem.pop_front();
        if (f_corrupt && rd_idx == 4) w_tmp[0] = ~w_tmp[0];
        rd_idx <= rd_idx + 1;
        stage <= w_tmp;
      end
      rd_data_i <= stage;
      if (wr_en_o && !full_i && mem.size() < DEPTH) mem.push_back(wr_data_o);
      fcnt <= mem.size();
    end
  end

  // monitor: write-stream check and verdict scoreboard
  always @(negedge clk_i) begin
    if (rst_i || (start_i && !busy_o)) begin
      wl = SEED;
      wr_seen = 0;
    end else if (wr_en_o && !full_i) begin
      chk("wr_data", 64'(wr_data_o), 64'(word(wl)));
      wl = step(wl);
      wr_seen++;
    end
    if (done_o && !done_prev) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'(done_o), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk({e.name, "_pass"}, 64'(pass_o), 64'(e.pass));
        chk({e.name, "_err_cnt"}, 64'(err_cnt_o), 64'(e.err));
        chk({e.name, "_first_idx"}, 64'(first_err_idx_o), 64'(e.idx));
        chk({e.name, "_flag_err"}, 64'(flag_err_o), 64'(e.flag));
        chk({e.name, "_timeout"}, 64'(timeout_o), 64'(e.to));
        chk({e.name, "_busy"}, 64'(busy_o), 64'(0));
      end
    end
    done_prev = done_o;
  end

  task automatic pulse_start(input logic [1:0] m);
    @(posedge clk_i); #1;
    mode_i = m;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask
  task automatic wait_done(input string n);
    for (int k = 0; k < 20000 && !done_o; k++) begin
      @(posedge clk_i); #1;
    end
    if (!done_o) chk({n, "_done_wait"}, 64'(done_o), 64'(1));
    repeat (3) @(posedge clk_i);
    #1;
  endtask
  task automatic run(input string n, input logic [1:0] m, input bit c, fl, ep,
                     input bit p, input bit [15:0] er, input bit [15:0] ix, input bit fe, input bit to);
    f_corrupt = c;
    f_full_low = fl;
    f_empty_pin = ep;
    exp_q.push_back('{name: n, pass: p, err: er, idx: ix, flag: fe, to: to});
    pulse_start(m);
    wait_done(n);
  endtask
  task automatic check_reset(input string n);
    chk({n, "_wr_en"}, 64'(wr_en_o), 0);
    chk({n, "_rd_en"}, 64'(rd_en_o), 0);
    chk({n, "_wr_data"}, 64'(wr_data_o), 0);
    chk({n, "_busy"}, 64'(busy_o), 0);
    chk({n, "_done"}, 64'(done_o), 0);
    chk({n, "_pass"}, 64'(pass_o), 0);
    chk({n, "_timeout"}, 64'(timeout_o), 0);
    chk({n, "_err_cnt"}, 64'(err_cnt_o), 0);
    chk({n, "_flag_err"}, 64'(flag_err_o), 0);
    chk({n, "_first_idx"}, 64'(first_err_idx_o), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset("reset");
    run("fill_drain", 2'd0, 0, 0, 0, 1, 0, 0, 0, 0);
    run("stream", 2'd1, 0, 0, 0, 1, 0, 0, 0, 0);
    run("throttled", 2'd2, 0, 0, 0, 1, 0, 0, 0, 0);
    run("corrupt5", 2'd0, 1, 0, 0, 0, 1, 4, 0, 0);
    run("full_low", 2'd0, 0, 1, 0, 0, 0, 0, 1, 0);
    run("empty_pin", 2'd1, 0, 0, 1, 0, 0, 0, 1, 1);
    f_corrupt = 0;
    f_full_low = 0;
    f_empty_pin = 0;
    pulse_start(2'd1);
    for (int k = 0; k < 5000 && wr_seen < 300; k++) begin
      @(posedge clk_i); #1;
    end
    chk("abort_reached_300", 64'(wr_seen >= 300), 1);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset("abort");
    exp_q.push_back('{name: "after_abort", pass: 1, err: 0, idx: 0, flag: 0, to: 0});
    pulse_start(2'd3);
    repeat (40) @(posedge clk_i);
    pulse_start(2'd0);
    chk("start_while_busy", 64'(busy_o), 1);
    wait_done("after_abort");
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end
endmodule
